// File: rtl/des_pkg.sv
// Shared types and constants for the DES block feeder: FSM state encoding,
// packer byte index and a byte-lane insert helper.
package des_pkg;

  localparam int DES_BLK_W = 64;
  localparam int DES_KEY_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } feeder_state_t;

  typedef logic [2:0] byte_idx_t;

  // Byte 0 of a block lands in the top lane, byte 7 in the bottom lane.
  function automatic logic [DES_BLK_W-1:0] pack_byte(input logic [DES_BLK_W-1:0] blk,
                                                     input byte_idx_t             idx,
                                                     input logic [7:0]            b);
    logic [DES_BLK_W-1:0] r;
    r = blk;
    for (int i = 0; i < 8; i++) begin
      if (idx == byte_idx_t'(i)) r[DES_BLK_W-1-8*i -: 8] = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/des_block_fifo.sv
// Block FIFO between the byte packer and the DES issue FSM. Head is read
// straight from storage; there is no show-ahead register.
module des_block_fifo
  import des_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = DES_BLK_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  // Guard against overflow/underflow even though the feeder never asks for either.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd];
  assign o_full  = (r_level == FULL_LVL);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/des_block_feeder.sv
// Packs a byte stream into 64-bit blocks, buffers them, and hands blocks and
// keys to the single-block DES core one at a time.
module des_block_feeder
  import des_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BUSY_WAIT  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_en,
  input  logic [7:0]                    s_byte,
  input  logic                          s_valid,
  input  logic                          s_last,
  output logic                          s_ready,
  input  logic [DES_KEY_W-1:0]          key_cfg,
  input  logic                          mode_cfg,
  input  logic                          key_load,
  output logic                          key_pending,
  output logic [DES_BLK_W-1:0]          des_data,
  output logic                          des_data_en,
  output logic [DES_KEY_W-1:0]          des_key,
  output logic                          des_mode,
  output logic                          des_key_en,
  input  logic                          des_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          timeout_err,
  output logic [15:0]                   blocks_done
);

  localparam int CW = $clog2(BUSY_WAIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_WAIT - 1);

  logic [DES_BLK_W-1:0] r_pack;
  byte_idx_t            r_idx;
  logic [DES_BLK_W-1:0] w_blk;
  logic                 w_accept;
  logic                 w_commit;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic [DES_BLK_W-1:0] w_head;

  feeder_state_t        r_state;
  logic [CW-1:0]        r_cnt;
  logic [DES_KEY_W-1:0] r_stg_key;
  logic                 r_stg_mode;
  logic                 r_key_pending;
  logic [DES_BLK_W-1:0] r_des_data;
  logic                 r_data_en;
  logic [DES_KEY_W-1:0] r_des_key;
  logic                 r_des_mode;
  logic                 r_key_en;
  logic                 r_timeout;
  logic [15:0]          r_blocks;

  assign s_ready  = !w_full;
  assign w_accept = s_valid && !w_full && clk_en;
  assign w_blk    = pack_byte(r_pack, r_idx, s_byte);
  // Unfilled low lanes are already zero, so s_last can commit the partial block as-is.
  assign w_commit = w_accept && ((r_idx == 3'd7) || s_last);
  assign w_pop    = clk_en && (r_state == ST_ISSUE);

  // Packer stage: assemble bytes, commit on the eighth byte or s_last
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pack <= '0;
      r_idx  <= '0;
    end else if (w_accept) begin
      if (w_commit) begin
        r_pack <= '0;
        r_idx  <= '0;
      end else begin
        r_pack <= w_blk;
        r_idx  <= r_idx + 1'b1;
      end
    end
  end

  des_block_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DES_BLK_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_commit),
    .i_data  (w_blk),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  // Issue stage: key staging plus block/key handoff to the core
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_stg_key     <= '0;
      r_stg_mode    <= 1'b0;
      r_key_pending <= 1'b0;
      r_des_data    <= '0;
      r_data_en     <= 1'b0;
      r_des_key     <= '0;
      r_des_mode    <= 1'b0;
      r_key_en      <= 1'b0;
      r_timeout     <= 1'b0;
      r_blocks      <= '0;
    end else if (!clk_en) begin
      r_data_en <= 1'b0;
      r_key_en  <= 1'b0;
    end else begin
      r_data_en <= 1'b0;
      r_key_en  <= 1'b0;
      if (key_load) begin
        r_stg_key     <= key_cfg;
        r_stg_mode    <= mode_cfg;
        r_key_pending <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (r_key_pending && !des_busy)  r_state <= ST_KEY;
          else if (!w_empty && !des_busy)  r_state <= ST_ISSUE;
        end
        ST_KEY: begin
          r_des_key  <= r_stg_key;
          r_des_mode <= r_stg_mode;
          r_key_en   <= 1'b1;
          // A key_load landing this cycle keeps pending set for its newer key.
          if (!key_load) r_key_pending <= 1'b0;
          r_state    <= ST_IDLE;
        end
        ST_ISSUE: begin
          r_des_data <= w_head;
          r_data_en  <= 1'b1;
          r_cnt      <= '0;
          r_state    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (des_busy) begin
            r_state <= ST_WAIT_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!des_busy) begin
            r_blocks <= r_blocks + 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign key_pending = r_key_pending;
  assign des_data    = r_des_data;
  assign des_data_en = r_data_en && clk_en;
  assign des_key     = r_des_key;
  assign des_mode    = r_des_mode;
  assign des_key_en  = r_key_en && clk_en;
  assign timeout_err = r_timeout;
  assign blocks_done = r_blocks;

endmodule

// File: tb/tb_des_block_feeder.sv
// Directed bench for des_block_feeder: key load, packing, FIFO backpressure,
// key/block ordering, busy timeout, reset and clock-enable freeze.
module tb_des_block_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [7:0]  s_byte;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [63:0] key_cfg;
  logic        mode_cfg;
  logic        key_load;
  logic        key_pending;
  logic [63:0] des_data;
  logic        des_data_en;
  logic [63:0] des_key;
  logic        des_mode;
  logic        des_key_en;
  logic        des_busy;
  logic [2:0]  fifo_level;
  logic        timeout_err;
  logic [15:0] blocks_done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_blk [5];

  des_block_feeder #(.FIFO_DEPTH(4), .BUSY_WAIT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .s_byte      (s_byte),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .key_cfg     (key_cfg),
    .mode_cfg    (mode_cfg),
    .key_load    (key_load),
    .key_pending (key_pending),
    .des_data    (des_data),
    .des_data_en (des_data_en),
    .des_key     (des_key),
    .des_mode    (des_mode),
    .des_key_en  (des_key_en),
    .des_busy    (des_busy),
    .fifo_level  (fifo_level),
    .timeout_err (timeout_err),
    .blocks_done (blocks_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    s_byte  = b;
    s_valid = 1'b1;
    s_last  = last;
    while (!s_ready && n < 200) begin
      tick();
      n++;
    end
    if (!s_ready) chk("s_ready_wait", 64'd0, 64'd1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_block(input logic [63:0] blk);
    for (int i = 0; i < 8; i++) send_byte(blk[63-8*i -: 8], 1'b0);
  endtask

  task automatic wait_data_en(input int max);
    int n;
    n = 0;
    while (!des_data_en && n < max) begin
      tick();
      n++;
    end
    if (!des_data_en) chk("data_en_wait", 64'd0, 64'd1);
  endtask

  task automatic finish_block();
    des_busy = 1'b1;
    tick();
    des_busy = 1'b0;
    tick();
  endtask

  task automatic core_serve(input int nblk);
    for (int k = 0; k < nblk; k++) begin
      wait_data_en(300);
      chk($sformatf("order_blk%0d", k), des_data, exp_blk[k]);
      finish_block();
    end
  endtask

  initial begin
    int key_t;
    int data_t;
    int cnt;
    logic [63:0] got_blk;

    rst = 1'b1; clk_en = 1'b1; s_byte = '0; s_valid = 1'b0; s_last = 1'b0;
    key_cfg = '0; mode_cfg = 1'b0; key_load = 1'b0; des_busy = 1'b0;
    tick(); tick();
    chk("rst_data", des_data, 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_blocks", 64'(blocks_done), 64'd0);
    chk("rst_strobes", {62'd0, des_data_en, des_key_en}, 64'd0);
    chk("rst_flags", {62'd0, key_pending, timeout_err}, 64'd0);
    rst = 1'b0;
    tick();
    chk("rst_s_ready", 64'(s_ready), 64'd1);

    // Test 1: key load with idle core
    key_cfg = 64'ha1b2c3d4e5f61234; mode_cfg = 1'b0; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    chk("t1_pending_set", 64'(key_pending), 64'd1);
    chk("t1_key_en_c1", 64'(des_key_en), 64'd0);
    tick();
    chk("t1_key_en_c2", 64'(des_key_en), 64'd0);
    tick();
    chk("t1_key_en", 64'(des_key_en), 64'd1);
    chk("t1_key", des_key, 64'ha1b2c3d4e5f61234);
    chk("t1_mode", 64'(des_mode), 64'd0);
    chk("t1_pending_clr", 64'(key_pending), 64'd0);
    tick();
    chk("t1_key_en_1cyc", 64'(des_key_en), 64'd0);

    // Test 2: full eight-byte block, two-cycle issue latency
    send_block(64'h85abcd1a98876543);
    chk("t2_level_commit", 64'(fifo_level), 64'd1);
    chk("t2_en_c0", 64'(des_data_en), 64'd0);
    tick();
    chk("t2_en_c1", 64'(des_data_en), 64'd0);
    tick();
    chk("t2_en_c2", 64'(des_data_en), 64'd1);
    chk("t2_data", des_data, 64'h85abcd1a98876543);
    chk("t2_level_pop", 64'(fifo_level), 64'd0);
    tick();
    chk("t2_en_1cyc", 64'(des_data_en), 64'd0);
    des_busy = 1'b1;
    tick(); tick();
    chk("t2_blocks_busy", 64'(blocks_done), 64'd0);
    des_busy = 1'b0;
    tick();
    chk("t2_blocks_done", 64'(blocks_done), 64'd1);

    // Test 3: partial block closed by s_last
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    wait_data_en(10);
    chk("t3_data", des_data, 64'h1122330000000000);
    finish_block();
    chk("t3_blocks", 64'(blocks_done), 64'd2);

    // Test 4: backpressure while the core is busy, then in-order drain
    for (int k = 0; k < 5; k++) exp_blk[k] = 64'hc0de0000000000a0 + 64'(k);
    des_busy = 1'b1;
    for (int k = 0; k < 4; k++) send_block(exp_blk[k]);
    chk("t4_level_full", 64'(fifo_level), 64'd4);
    chk("t4_s_ready_full", 64'(s_ready), 64'd0);
    tick();
    chk("t4_no_issue_busy", 64'(fifo_level), 64'd4);
    des_busy = 1'b0;
    fork
      send_block(exp_blk[4]);
      core_serve(5);
    join
    chk("t4_level_empty", 64'(fifo_level), 64'd0);
    chk("t4_blocks", 64'(blocks_done), 64'd7);

    // Test 5: key_load during WAIT_DONE goes out between blocks
    des_busy = 1'b1;
    send_block(64'h0a0a0a0a0a0a0a0a);
    send_block(64'h0b0b0b0b0b0b0b0b);
    chk("t5_level2", 64'(fifo_level), 64'd2);
    des_busy = 1'b0;
    wait_data_en(10);
    chk("t5_blkA", des_data, 64'h0a0a0a0a0a0a0a0a);
    des_busy = 1'b1;
    tick();
    key_cfg = 64'h0123456789abcdef; mode_cfg = 1'b1; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    chk("t5_pending", 64'(key_pending), 64'd1);
    tick(); tick();
    chk("t5_no_key_busy", 64'(des_key_en), 64'd0);
    des_busy = 1'b0;
    key_t = 0; data_t = 0; got_blk = '0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (des_key_en && key_t == 0) key_t = t;
      if (des_data_en && data_t == 0) begin
        data_t  = t;
        got_blk = des_data;
      end
    end
    chk("t5_key_cycle", 64'(key_t), 64'd3);
    chk("t5_data_cycle", 64'(data_t), 64'd5);
    chk("t5_key", des_key, 64'h0123456789abcdef);
    chk("t5_mode", 64'(des_mode), 64'd1);
    chk("t5_blkB", got_blk, 64'h0b0b0b0b0b0b0b0b);
    finish_block();
    chk("t5_blocks", 64'(blocks_done), 64'd9);

    // Test 6: busy never rises -> timeout exactly BUSY_WAIT cycles later
    send_block(64'hdeadbeef00c0ffee);
    wait_data_en(10);
    cnt = 0;
    while (!timeout_err && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("t6_timeout_cycles", 64'(cnt), 64'd8);
    tick(); tick(); tick();
    chk("t6_timeout_sticky", 64'(timeout_err), 64'd1);
    chk("t6_blocks_unchanged", 64'(blocks_done), 64'd9);

    // Reset mid-stream with buffered block, pending key and partial block
    des_busy = 1'b1;
    send_block(64'h5555555555555555);
    key_cfg = 64'hffffffffffffffff; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    send_byte(8'haa, 1'b0);
    send_byte(8'hbb, 1'b0);
    send_byte(8'hcc, 1'b0);
    chk("t6_pre_level", 64'(fifo_level), 64'd1);
    rst = 1'b1;
    tick();
    chk("t6_rst_data", des_data, 64'd0);
    chk("t6_rst_key", des_key, 64'd0);
    chk("t6_rst_level", 64'(fifo_level), 64'd0);
    chk("t6_rst_blocks", 64'(blocks_done), 64'd0);
    chk("t6_rst_flags", {61'd0, key_pending, timeout_err, des_mode}, 64'd0);
    chk("t6_rst_strobes", {62'd0, des_data_en, des_key_en}, 64'd0);
    rst = 1'b0; des_busy = 1'b0;
    tick();

    // clk_en freeze: block is buffered but the FSM must not move
    send_block(64'h0102030405060708);
    clk_en = 1'b0;
    chk("t6_frz_level0", 64'(fifo_level), 64'd1);
    s_byte = 8'hff; s_valid = 1'b1; s_last = 1'b1;
    cnt = 0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (des_data_en) cnt++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk("t6_frz_level", 64'(fifo_level), 64'd1);
    chk("t6_frz_no_strobe", 64'(cnt), 64'd0);
    clk_en = 1'b1;
    tick();
    chk("t6_resume_c1", 64'(des_data_en), 64'd0);
    tick();
    chk("t6_resume_c2", 64'(des_data_en), 64'd1);
    chk("t6_resume_data", des_data, 64'h0102030405060708);
    finish_block();
    chk("t6_resume_blocks", 64'(blocks_done), 64'd1);
    chk("t6_resume_level", 64'(fifo_level), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
